// File: rtl/riscv_fetch.sv
// Instruction fetch unit: one outstanding imem request feeding an in-order DEPTH-entry buffer.
// Define RISCV_FETCH_PERF_EN to add the fetch_count port (wrapping count of consumed instructions).
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready
`ifdef RISCV_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  // Handshakes: imem_req/imem_addr hold until imem_gnt (a redirect may retarget the address);
  // each grant yields exactly one imem_rvalid beat, no earlier than the next cycle;
  // the head entry is consumed on a cycle where ins_valid && ins_ready.

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          outstanding;
  logic          discard;
  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic granted;
  logic resp;
  logic push;
  logic pop;
  logic still_waiting;

  assign imem_req      = reset && !outstanding && (count < FULL);
  assign imem_addr     = fetch_pc;
  assign granted       = imem_req && imem_gnt;
  assign resp          = outstanding && imem_rvalid;
  assign push          = resp && !discard && !redirect;
  assign ins_valid     = reset && (count != '0);
  assign pop           = ins_valid && ins_ready && !redirect;
  assign still_waiting = outstanding && !imem_rvalid;

  assign PC  = ins_valid ? fifo_pc[head]  : 32'h0000_0000;
  assign ins = ins_valid ? fifo_ins[head] : NOP;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_addr    <= 32'h0000_0000;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      // A response still in flight after this edge belongs to the old path and must be dropped.
      fetch_pc    <= redirect_pc & ~32'h0000_0003;
      outstanding <= granted || still_waiting;
      discard     <= granted || still_waiting;
      if (granted) begin
        req_addr <= fetch_pc;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (granted) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]  <= req_addr;
      fifo_ins[tail] <= imem_rdata;
    end
  end

`ifdef RISCV_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= 32'h0000_0000;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule
